// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status bit positions and default datapath width.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam int STAT_N = 2;
  localparam int STAT_V = 1;
  localparam int STAT_Z = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {N,V,Z} flag generation from the ALU result sign, zero flag, operand signs and opcode.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic       alu_msb,
  input  logic       alu_z,
  input  logic       ain_msb,
  input  logic       bin_msb,
  input  logic [1:0] aluop,
  output logic [2:0] flags
);

  logic v_s;

  // Signed overflow exists only for the arithmetic opcodes.
  always_comb begin
    v_s = 1'b0;
    case (aluop)
      ALU_ADD: v_s = (ain_msb == bin_msb) && (alu_msb != ain_msb);
      ALU_SUB: v_s = (ain_msb != bin_msb) && (alu_msb != ain_msb);
      ALU_AND: v_s = 1'b0;
      ALU_NOT: v_s = 1'b0;
      default: v_s = 1'b0;
    endcase
  end

  // Pack the flags into the architectural {N,V,Z} layout.
  always_comb begin
    flags         = 3'b000;
    flags[STAT_N] = alu_msb;
    flags[STAT_V] = v_s;
    flags[STAT_Z] = alu_z;
  end

endmodule

// File: rtl/alu_status_stage.sv
// ALU result/status stage: status register plus a DEPTH-entry result FIFO toward writeback.
// Optional macro ALU_STATUS_BYPASS_EN adds a 0-cycle empty-FIFO bypass path.
module alu_status_stage
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] alu_out,
  input  logic         alu_z,
  input  logic         ain_msb,
  input  logic         bin_msb,
  input  logic [1:0]   aluop,
  input  logic         loads,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c_out,
  output logic [2:0]   status
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ZERO = (PW + 1)'(0);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [PW:0]   count_r;
  logic [PW:0]   count_nxt_s;
  logic [PW:0]   remain_s;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [W-1:0]  c_out_r;
  logic [W-1:0]  head_nxt_s;
  logic [2:0]    status_r;
  logic [2:0]    flags_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          byp_take_s;

  alu_flag_gen u_flag_gen (
    .alu_msb (alu_out[W-1]),
    .alu_z   (alu_z),
    .ain_msb (ain_msb),
    .bin_msb (bin_msb),
    .aluop   (aluop),
    .flags   (flags_s)
  );

  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;

`ifdef ALU_STATUS_BYPASS_EN
  logic byp_s;
  // An accept into an empty FIFO is presented directly; if taken now it never enters storage.
  assign byp_s      = accept_s & (count_r == CNT_ZERO);
  assign byp_take_s = byp_s & out_ready;
  assign out_valid  = out_valid_r | byp_s;
  assign c_out      = byp_s ? alu_out : c_out_r;
`else
  assign byp_take_s = 1'b0;
  assign out_valid  = out_valid_r;
  assign c_out      = c_out_r;
`endif

  assign push_s   = accept_s & ~byp_take_s;
  assign in_ready = in_ready_r;
  assign status   = status_r;

  // Next pointer/count and the value that becomes the registered head after this edge.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    remain_s     = count_r;
    head_nxt_s   = c_out_r;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      remain_s     = count_r - CNT_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
      remain_s     = count_r;
    end
    count_nxt_s = remain_s + (push_s ? CNT_ONE : CNT_ZERO);
    // Older entries stay ahead of the new push; an emptied FIFO keeps the last popped value.
    if (remain_s != CNT_ZERO) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else if (push_s || byp_take_s) begin
      head_nxt_s = alu_out;
    end else begin
      head_nxt_s = c_out_r;
    end
  end

  // Result storage; contents are meaningless unless covered by the count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= alu_out;
    end
  end

  // Pointers, occupancy, registered handshake outputs and the status register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= CNT_ZERO;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      c_out_r     <= {W{1'b0}};
      status_r    <= 3'b000;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != FULL_CNT);
      out_valid_r <= (count_nxt_s != CNT_ZERO);
      c_out_r     <= head_nxt_s;
      if (accept_s && loads) begin
        status_r <= flags_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_status_stage.sv
// Directed and scoreboard checks for alu_status_stage (default build, no bypass).
module tb_alu_status_stage;
  import alu_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] alu_out = 16'h0000;
  logic         alu_z = 1'b0;
  logic         ain_msb = 1'b0;
  logic         bin_msb = 1'b0;
  logic [1:0]   aluop = 2'b00;
  logic         loads = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] c_out;
  logic [2:0]   status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_status_stage #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .ain_msb   (ain_msb),
    .bin_msb   (bin_msb),
    .aluop     (aluop),
    .loads     (loads),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .status    (status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic z, input logic am, input logic bm,
                       input logic [1:0] op, input logic ld);
    in_valid = 1'b1;
    alu_out  = d;
    alu_z    = z;
    ain_msb  = am;
    bin_msb  = bm;
    aluop    = op;
    loads    = ld;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (c_out !== 16'h0000) begin errors++; $display("FAIL reset_c_out got %h exp 0000", c_out); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", status); end
    reset_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_add_overflow();
    drive(16'h8000, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (status !== 3'b110) begin errors++; $display("FAIL add_ovf_status got %b exp 110", status); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_ovf_valid got %b exp 1", out_valid); end
    checks++; if (c_out !== 16'h8000) begin errors++; $display("FAIL add_ovf_c_out got %h exp 8000", c_out); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    checks++; if (c_out !== 16'h8000) begin errors++; $display("FAIL empty_hold_c_out got %h exp 8000", c_out); end
  endtask

  task automatic test_zero_sub();
    drive(16'h0000, 1'b1, 1'b0, 1'b0, ALU_SUB, 1'b1);
    tick();
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL sub_zero_status got %b exp 001", status); end
    drive(16'h0003, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL noload_status got %b exp 001", status); end
    checks++; if (c_out !== 16'h0000) begin errors++; $display("FAIL sub_head got %h exp 0000", c_out); end
    out_ready = 1'b1;
    tick();
    checks++; if (c_out !== 16'h0003) begin errors++; $display("FAIL sub_second got %h exp 0003", c_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_second_valid got %b exp 1", out_valid); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_flags();
    logic [15:0] d_t  [5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
    logic        z_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        am_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        bm_t [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  op_t [5] = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_NOT, ALU_AND};
    logic [2:0]  st_t [5] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b100};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(d_t[i], z_t[i], am_t[i], bm_t[i], op_t[i], 1'b1);
      tick();
      checks++; if (status !== st_t[i]) begin errors++; $display("FAIL flags_%0d_status got %b exp %b", i, status, st_t[i]); end
      checks++; if (c_out !== d_t[i]) begin errors++; $display("FAIL flags_%0d_c_out got %h exp %h", i, c_out, d_t[i]); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flags_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(16'h0001, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    drive(16'h0002, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", in_ready); end
    drive(16'h0003, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b exp 0", in_ready); end
    checks++; if (status !== 3'b100) begin errors++; $display("FAIL bp_reject_status got %b exp 100", status); end
    checks++; if (c_out !== 16'h0001) begin errors++; $display("FAIL bp_head got %h exp 0001", c_out); end
    out_ready = 1'b1;
    tick();
    checks++; if (c_out !== 16'h0002) begin errors++; $display("FAIL bp_pop1 got %h exp 0002", c_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_only_ready got %b exp 1", in_ready); end
    checks++; if (status !== 3'b100) begin errors++; $display("FAIL bp_pop_only_status got %b exp 100", status); end
    tick();
    in_valid = 1'b0;
    checks++; if (c_out !== 16'h0003) begin errors++; $display("FAIL bp_pop2 got %h exp 0003", c_out); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL bp_accept_status got %b exp 000", status); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", out_valid); end
    checks++; if (c_out !== 16'h0003) begin errors++; $display("FAIL bp_last_pop got %h exp 0003", c_out); end
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [15:0] last = 16'h0003;
    logic [2:0]  exp_st = 3'b000;
    logic        acc;
    logic        pop;
    logic        v;
    for (int i = 0; i < 100; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      alu_out   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) alu_out = 16'h0000;
      alu_z     = (alu_out == 16'h0000);
      ain_msb   = 1'($urandom_range(0, 1));
      bin_msb   = 1'($urandom_range(0, 1));
      aluop     = 2'($urandom_range(0, 3));
      loads     = 1'($urandom_range(0, 1));
      acc = in_valid && (q.size() < DEPTH);
      pop = (q.size() > 0) && out_ready;
      case (aluop)
        2'b00:   v = (ain_msb == bin_msb) && (alu_out[15] != ain_msb);
        2'b01:   v = (ain_msb != bin_msb) && (alu_out[15] != ain_msb);
        default: v = 1'b0;
      endcase
      if (acc && loads) exp_st = {alu_out[15], v, alu_z};
      if (pop) last = q.pop_front();
      if (acc) q.push_back(alu_out);
      tick();
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_%0d_valid got %b exp %b", i, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_%0d_ready got %b exp %b", i, in_ready, q.size() < DEPTH); end
      checks++; if (status !== exp_st) begin errors++; $display("FAIL rnd_%0d_status got %b exp %b", i, status, exp_st); end
      if (q.size() > 0) begin
        checks++; if (c_out !== q[0]) begin errors++; $display("FAIL rnd_%0d_c_out got %h exp %h", i, c_out, q[0]); end
      end else begin
        checks++; if (c_out !== last) begin errors++; $display("FAIL rnd_%0d_hold got %h exp %h", i, c_out, last); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(16'h8000, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1);
    tick();
    drive(16'h1234, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b exp 1", out_valid); end
    checks++; if (status !== 3'b110) begin errors++; $display("FAIL ar_pre_status got %b exp 110", status); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", out_valid); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL ar_status got %b exp 000", status); end
    checks++; if (c_out !== 16'h0000) begin errors++; $display("FAIL ar_c_out got %h exp 0000", c_out); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_empty got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_zero_sub();
    test_flags();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
